// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: icache request/response and decode handoff bundle for the fetch sequencer
interface fetch_pc_ctrl_if #(parameter int ADDR_W = 32);
  logic              ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic [31:0]       ic_resp_inst;
  logic              dec_valid, dec_ready, dec_is_c;
  logic [31:0]       dec_inst;
  logic [ADDR_W-1:0] dec_pc, dec_pred_pc;
  modport master (
    output ic_req_valid, ic_req_addr, dec_valid, dec_inst, dec_pc, dec_pred_pc, dec_is_c,
    input  ic_req_ready, ic_resp_valid, ic_resp_inst, dec_ready
  );
  modport slave (
    input  ic_req_valid, ic_req_addr, dec_valid, dec_inst, dec_pc, dec_pred_pc, dec_is_c,
    output ic_req_ready, ic_resp_valid, ic_resp_inst, dec_ready
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC sequencer between icache, next-PC predictor and decode.
// Define RVC_EN to support 16-bit compressed instructions (len 2 when inst[1:0] != 2'b11).
module fetch_pc_ctrl #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  fetch_pc_ctrl_if.master   bus,
  output logic [ADDR_W-1:0] pred_pc_out,
  output logic [31:0]       pred_inst_out,
  input  logic [6:0]        pred_op_type_in,
  input  logic [ADDR_W-1:0] pred_next_pc_in,
  input  logic              jalr_src_rdy_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] flush_pc_in
);
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_B_TYPE = 7'b1100011;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, len, next_pc;
  logic [31:0]       inst_q, inst_d;
  logic              is_c, is_ctrl, jalr_ok, dec_fire, outstanding;
`ifdef RVC_EN
  assign is_c = inst_q[1:0] != 2'b11;
`else
  assign is_c = 1'b0;
`endif
  assign len     = is_c ? ADDR_W'(2) : ADDR_W'(4);
  assign is_ctrl = pred_op_type_in == OP_JAL || pred_op_type_in == OP_JALR || pred_op_type_in == OP_B_TYPE;
  assign next_pc = is_ctrl ? pred_next_pc_in : pc_q + len;
  assign jalr_ok = pred_op_type_in != OP_JALR || jalr_src_rdy_in;
  assign bus.ic_req_valid = state_q == REQ && rdy_in;
  assign bus.ic_req_addr  = pc_q;
  assign bus.dec_valid    = state_q == HOLD && rdy_in && !flush_in && jalr_ok;
  assign bus.dec_inst     = inst_q;
  assign bus.dec_pc       = pc_q;
  assign bus.dec_pred_pc  = next_pc;
  assign bus.dec_is_c     = is_c;
  assign pred_pc_out      = pc_q;
  assign pred_inst_out    = inst_q;
  assign dec_fire         = bus.dec_valid && bus.dec_ready;
  // a response still owed by the icache must be swallowed after a redirect
  assign outstanding = ((state_q == WAIT || state_q == DRAIN) && !bus.ic_resp_valid) ||
                       (state_q == REQ && bus.ic_req_ready);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (rdy_in && flush_in) begin
      pc_d    = flush_pc_in;
      state_d = outstanding ? DRAIN : REQ;
    end else if (rdy_in) begin
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = bus.ic_req_ready ? WAIT : REQ;
        WAIT:    begin
          inst_d  = bus.ic_resp_valid ? bus.ic_resp_inst : inst_q;
          state_d = bus.ic_resp_valid ? HOLD : WAIT;
        end
        HOLD:    begin
          pc_d    = dec_fire ? next_pc : pc_q;
          state_d = dec_fire ? REQ : HOLD;
        end
        DRAIN:   state_d = bus.ic_resp_valid ? REQ : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed bench acting as icache, predictor and decoder around fetch_pc_ctrl
module tb_fetch_pc_ctrl;
  logic        clk = 0, rst_n = 0, rdy = 1, jsr = 0, flush = 0;
  logic [6:0]  op = 7'h13;
  logic [31:0] npc = 0, fpc = 0, pred_pc, pred_inst, exp_pc;
  logic        exp_c;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  fetch_pc_ctrl_if #(.ADDR_W(32)) bus ();
  fetch_pc_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .bus(bus),
    .pred_pc_out(pred_pc), .pred_inst_out(pred_inst), .pred_op_type_in(op),
    .pred_next_pc_in(npc), .jalr_src_rdy_in(jsr), .flush_in(flush), .flush_pc_in(fpc)
  );
  // called at a negedge with the DUT in REQ; returns at the negedge after the word is latched
  task automatic icache_fetch(input logic [31:0] inst);
    bus.ic_req_ready = 1;
    @(negedge clk);
    bus.ic_req_ready = 0;
    bus.ic_resp_valid = 1;
    bus.ic_resp_inst = inst;
    @(negedge clk);
    bus.ic_resp_valid = 0;
  endtask
  task automatic test_reset;
    bus.ic_req_ready = 0; bus.ic_resp_valid = 0; bus.ic_resp_inst = 0; bus.dec_ready = 0;
    rst_n = 0;
    @(negedge clk); #1;
    total++; if (bus.ic_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", bus.ic_req_valid); end
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%b exp=0", bus.dec_valid); end
    total++; if (pred_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pred_pc); end
    total++; if (pred_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", pred_inst); end
    @(negedge clk);
    rst_n = 1; #1;
    total++; if (bus.ic_req_valid !== 1'b0) begin bad++; $display("FAIL idle_req_valid got=%b exp=0", bus.ic_req_valid); end
    @(negedge clk); #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", bus.ic_req_valid, bus.ic_req_addr); end
  endtask
  task automatic test_sequential;
    @(negedge clk); #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h0) begin bad++; $display("FAIL req_stable got=%b/%h exp=1/0", bus.ic_req_valid, bus.ic_req_addr); end
    op = 7'h13; npc = 32'hdead0000;
    icache_fetch(32'h00500093); #1;
    total++; if (bus.dec_valid !== 1'b1) begin bad++; $display("FAIL seq_dec_valid got=%b exp=1", bus.dec_valid); end
    total++; if (bus.dec_pc !== 32'h0 || bus.dec_pred_pc !== 32'h4) begin bad++; $display("FAIL seq_pcs got=%h/%h exp=0/4", bus.dec_pc, bus.dec_pred_pc); end
    total++; if (bus.dec_inst !== 32'h00500093 || bus.dec_is_c !== 1'b0) begin bad++; $display("FAIL seq_inst got=%h/%b exp=00500093/0", bus.dec_inst, bus.dec_is_c); end
    bus.dec_ready = 1;
    @(negedge clk);
    bus.dec_ready = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h4) begin bad++; $display("FAIL seq_next_req got=%b/%h exp=1/4", bus.ic_req_valid, bus.ic_req_addr); end
  endtask
  task automatic test_back_to_back;
    icache_fetch(32'h00100113);
    bus.dec_ready = 1;
    @(negedge clk);
    bus.dec_ready = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h8) begin bad++; $display("FAIL b2b_req got=%b/%h exp=1/8", bus.ic_req_valid, bus.ic_req_addr); end
  endtask
  task automatic test_jal;
    op = 7'h6f; npc = 32'h200;
    icache_fetch(32'h1f80006f); #1;
    total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h8 || bus.dec_pred_pc !== 32'h200) begin bad++; $display("FAIL jal_dec got=%b/%h/%h exp=1/8/200", bus.dec_valid, bus.dec_pc, bus.dec_pred_pc); end
    bus.dec_ready = 1;
    @(negedge clk);
    bus.dec_ready = 0; op = 7'h13; #1;
    total++; if (bus.ic_req_addr !== 32'h200) begin bad++; $display("FAIL jal_next_req got=%h exp=200", bus.ic_req_addr); end
  endtask
  task automatic test_rvc;
    flush = 1; fpc = 32'h10;
    @(negedge clk);
    flush = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h10) begin bad++; $display("FAIL flush_req_addr got=%b/%h exp=1/10", bus.ic_req_valid, bus.ic_req_addr); end
`ifdef RVC_EN
    exp_pc = 32'h12; exp_c = 1'b1;
`else
    exp_pc = 32'h14; exp_c = 1'b0;
`endif
    op = 7'h01; npc = 32'h999;
    icache_fetch(32'h00004501); #1;
    total++; if (bus.dec_pred_pc !== exp_pc || bus.dec_is_c !== exp_c) begin bad++; $display("FAIL rvc_dec got=%h/%b exp=%h/%b", bus.dec_pred_pc, bus.dec_is_c, exp_pc, exp_c); end
    bus.dec_ready = 1;
    @(negedge clk);
    bus.dec_ready = 0; #1;
    total++; if (bus.ic_req_addr !== exp_pc) begin bad++; $display("FAIL rvc_next_req got=%h exp=%h", bus.ic_req_addr, exp_pc); end
  endtask
  task automatic test_jalr;
    op = 7'h67; npc = 32'h300; jsr = 0;
    icache_fetch(32'h000080e7);
    bus.dec_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL jalr_stall%0d got=%b exp=0", i, bus.dec_valid); end
      @(negedge clk);
    end
    jsr = 1; #1;
    total++; if (bus.dec_valid !== 1'b1 || bus.dec_pred_pc !== 32'h300 || bus.dec_pc !== exp_pc) begin bad++; $display("FAIL jalr_go got=%b/%h/%h exp=1/300/%h", bus.dec_valid, bus.dec_pred_pc, bus.dec_pc, exp_pc); end
    @(negedge clk);
    bus.dec_ready = 0; jsr = 0; op = 7'h13; #1;
    total++; if (bus.ic_req_addr !== 32'h300) begin bad++; $display("FAIL jalr_next_req got=%h exp=300", bus.ic_req_addr); end
  endtask
  task automatic test_flush_wait;
    bus.ic_req_ready = 1;
    @(negedge clk);
    bus.ic_req_ready = 0; flush = 1; fpc = 32'h80; #1;
    total++; if (bus.ic_req_valid !== 1'b0 || bus.dec_valid !== 1'b0) begin bad++; $display("FAIL fw_wait got=%b/%b exp=0/0", bus.ic_req_valid, bus.dec_valid); end
    @(negedge clk);
    flush = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b0) begin bad++; $display("FAIL fw_drain1 got=%b exp=0", bus.ic_req_valid); end
    @(negedge clk);
    bus.ic_resp_valid = 1; bus.ic_resp_inst = 32'hbad00013; #1;
    total++; if (bus.ic_req_valid !== 1'b0) begin bad++; $display("FAIL fw_drain2 got=%b exp=0", bus.ic_req_valid); end
    @(negedge clk);
    bus.ic_resp_valid = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h80) begin bad++; $display("FAIL fw_req got=%b/%h exp=1/80", bus.ic_req_valid, bus.ic_req_addr); end
    total++; if (bus.dec_valid !== 1'b0 || pred_inst !== 32'h000080e7) begin bad++; $display("FAIL fw_stale got=%b/%h exp=0/000080e7", bus.dec_valid, pred_inst); end
  endtask
  task automatic test_flush_hold;
    icache_fetch(32'h00000013);
    bus.dec_ready = 1; flush = 1; fpc = 32'h40; #1;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL fh_dec_valid got=%b exp=0", bus.dec_valid); end
    @(negedge clk);
    bus.dec_ready = 0; flush = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h40) begin bad++; $display("FAIL fh_req got=%b/%h exp=1/40", bus.ic_req_valid, bus.ic_req_addr); end
  endtask
  task automatic test_rdy;
    rdy = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b0) begin bad++; $display("FAIL rdy_req_off got=%b exp=0", bus.ic_req_valid); end
    @(negedge clk);
    rdy = 1; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h40) begin bad++; $display("FAIL rdy_req_on got=%b/%h exp=1/40", bus.ic_req_valid, bus.ic_req_addr); end
    icache_fetch(32'h00000013);
    rdy = 0; bus.dec_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rdy_hold%0d got=%b exp=0", i, bus.dec_valid); end
      @(negedge clk);
    end
    rdy = 1; #1;
    total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h40) begin bad++; $display("FAIL rdy_resume got=%b/%h exp=1/40", bus.dec_valid, bus.dec_pc); end
    @(negedge clk);
    bus.dec_ready = 0; #1;
    total++; if (bus.ic_req_addr !== 32'h44) begin bad++; $display("FAIL rdy_next_req got=%h exp=44", bus.ic_req_addr); end
  endtask
  task automatic test_wrap;
    flush = 1; fpc = 32'hfffffffc;
    @(negedge clk);
    flush = 0;
    icache_fetch(32'h00000013); #1;
    total++; if (bus.dec_pc !== 32'hfffffffc || bus.dec_pred_pc !== 32'h0) begin bad++; $display("FAIL wrap_dec got=%h/%h exp=fffffffc/0", bus.dec_pc, bus.dec_pred_pc); end
    bus.dec_ready = 1;
    @(negedge clk);
    bus.dec_ready = 0; #1;
    total++; if (bus.ic_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_req got=%h exp=0", bus.ic_req_addr); end
  endtask
  task automatic test_flush_idle;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; flush = 1; fpc = 32'h500; #1;
    total++; if (bus.ic_req_valid !== 1'b0 || pred_pc !== 32'h0) begin bad++; $display("FAIL fi_idle got=%b/%h exp=0/0", bus.ic_req_valid, pred_pc); end
    @(negedge clk);
    flush = 0; #1;
    total++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h500) begin bad++; $display("FAIL fi_req got=%b/%h exp=1/500", bus.ic_req_valid, bus.ic_req_addr); end
  endtask
  initial begin
    test_reset;
    test_sequential;
    test_back_to_back;
    test_jal;
    test_rvc;
    test_jalr;
    test_flush_wait;
    test_flush_hold;
    test_rdy;
    test_wrap;
    test_flush_idle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
